// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem req/ready handshake, 1-entry skid, IF/ID register.
// Optional FETCH_PERF_CNT_EN adds fetched/discarded response counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic        validD,
  output logic        fetch_busy
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_discarded
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  localparam logic [31:0] STEP = PC_STEP[31:0];

  logic [1:0]  state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] redir_tgt;
  logic        redir_pend;
  logic        skid_vld;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc4;

  logic        active;
  logic        accept;
  logic        drop;
  logic        keep;
  logic [31:0] tgt;
  logic [31:0] pc_inc;

  assign active = (state == REQ) || (state == WAIT);
  assign accept = active && imem_ready;
  assign drop   = accept && (branch_taken || redir_pend || flushD);
  assign keep   = accept && !drop;
  assign tgt    = branch_target & ~32'h3;
  assign pc_inc = pc + STEP;

  assign imem_req   = active;
  assign imem_addr  = pc;
  assign fetch_busy = (state == WAIT);

  // A response taken under stall parks in the skid; HOLD stops further requests.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: state_n = REQ;
      REQ, WAIT: begin
        if (accept)
          state_n = (keep && stallD) ? HOLD : REQ;
        else
          state_n = WAIT;
      end
      HOLD: begin
        if (flushD || !stallD)
          state_n = REQ;
      end
      default: state_n = IDLE;
    endcase
  end

  // With a request outstanding, a redirect only takes effect at arrival.
  always_comb begin
    pc_n = pc;
    if (branch_taken && (!active || accept))
      pc_n = tgt;
    else if (accept && redir_pend)
      pc_n = redir_tgt;
    else if (keep)
      pc_n = pc_inc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      redir_pend <= 1'b0;
      redir_tgt  <= 32'h0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      if (accept) begin
        redir_pend <= 1'b0;
      end else if (branch_taken && active) begin
        redir_pend <= 1'b1;
        redir_tgt  <= tgt;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      InstrD     <= 32'h0;
      PCPlus4D   <= 32'h0;
      validD     <= 1'b0;
      skid_vld   <= 1'b0;
      skid_instr <= 32'h0;
      skid_pc4   <= 32'h0;
    end else if (keep) begin
      if (stallD) begin
        skid_vld   <= 1'b1;
        skid_instr <= imem_rdata;
        skid_pc4   <= pc_inc;
      end else if (skid_vld) begin
        InstrD     <= skid_instr;
        PCPlus4D   <= skid_pc4;
        validD     <= 1'b1;
        skid_instr <= imem_rdata;
        skid_pc4   <= pc_inc;
      end else begin
        InstrD   <= imem_rdata;
        PCPlus4D <= pc_inc;
        validD   <= 1'b1;
      end
    end else if (flushD) begin
      InstrD   <= 32'h0;
      PCPlus4D <= 32'h0;
      validD   <= 1'b0;
      skid_vld <= 1'b0;
    end else if (!stallD) begin
      if (skid_vld) begin
        InstrD   <= skid_instr;
        PCPlus4D <= skid_pc4;
        validD   <= 1'b1;
        skid_vld <= 1'b0;
      end else begin
        validD <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched   <= 32'h0;
      perf_discarded <= 32'h0;
    end else begin
      if (keep && perf_fetched != 32'hFFFF_FFFF)
        perf_fetched <= perf_fetched + 32'h1;
      if (drop && perf_discarded != 32'hFFFF_FFFF)
        perf_discarded <= perf_discarded + 32'h1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage.
// Memory returns the request address as instruction data.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stallD;
  logic        flushD;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] InstrD;
  logic [31:0] PCPlus4D;
  logic        validD;
  logic        fetch_busy;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_discarded;
`endif

  int tests = 0;
  int fails = 0;

  fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .stallD       (stallD),
    .flushD       (flushD),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .InstrD       (InstrD),
    .PCPlus4D     (PCPlus4D),
    .validD       (validD),
    .fetch_busy   (fetch_busy)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_discarded(perf_discarded)
`endif
  );

  assign imem_rdata = imem_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT one edge past release: REQ state, imem_addr = RESET_PC.
  task automatic do_reset();
    reset = 1'b0;
    imem_ready = 1'b1;
    stallD = 1'b0;
    flushD = 1'b0;
    branch_taken = 1'b0;
    branch_target = 32'h0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    imem_ready = 1'b1;
    stallD = 1'b0;
    flushD = 1'b0;
    branch_taken = 1'b0;
    branch_target = 32'h0;
    step();
    step();
    if (imem_req !== 1'b0) begin fails++; $display("FAIL rst_req got=%b exp=0", imem_req); end
    tests++;
    if (imem_addr !== 32'h0) begin fails++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
    tests++;
    if (InstrD !== 32'h0) begin fails++; $display("FAIL rst_instr got=%h exp=0", InstrD); end
    tests++;
    if (PCPlus4D !== 32'h0) begin fails++; $display("FAIL rst_pc4 got=%h exp=0", PCPlus4D); end
    tests++;
    if (validD !== 1'b0) begin fails++; $display("FAIL rst_valid got=%b exp=0", validD); end
    tests++;
    if (fetch_busy !== 1'b0) begin fails++; $display("FAIL rst_busy got=%b exp=0", fetch_busy); end
    tests++;
  endtask

  task automatic test_stream();
    do_reset();
    if (imem_req !== 1'b1) begin fails++; $display("FAIL str_req got=%b exp=1", imem_req); end
    tests++;
    if (imem_addr !== 32'h0) begin fails++; $display("FAIL str_addr0 got=%h exp=0", imem_addr); end
    tests++;
    if (validD !== 1'b0) begin fails++; $display("FAIL str_v0 got=%b exp=0", validD); end
    tests++;
    for (int k = 0; k < 3; k++) begin
      step();
      if (imem_addr !== 32'(4 * k + 4)) begin
        fails++; $display("FAIL str_addr k=%0d got=%h exp=%h", k, imem_addr, 32'(4 * k + 4));
      end
      tests++;
      if (InstrD !== 32'(4 * k) || validD !== 1'b1) begin
        fails++; $display("FAIL str_instr k=%0d got=%h/%b exp=%h/1", k, InstrD, validD, 32'(4 * k));
      end
      tests++;
      if (PCPlus4D !== 32'(4 * k + 4)) begin
        fails++; $display("FAIL str_pc4 k=%0d got=%h exp=%h", k, PCPlus4D, 32'(4 * k + 4));
      end
      tests++;
    end
  endtask

  task automatic test_wait();
    do_reset();
    step();
    step();
    if (InstrD !== 32'h4) begin fails++; $display("FAIL wt_pre got=%h exp=4", InstrD); end
    tests++;
    imem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (imem_addr !== 32'h8 || imem_req !== 1'b1) begin
        fails++; $display("FAIL wt_addr k=%0d got=%h/%b exp=8/1", k, imem_addr, imem_req);
      end
      tests++;
      if (fetch_busy !== 1'b1) begin fails++; $display("FAIL wt_busy k=%0d got=%b exp=1", k, fetch_busy); end
      tests++;
      if (validD !== 1'b0) begin fails++; $display("FAIL wt_bubble k=%0d got=%b exp=0", k, validD); end
      tests++;
    end
    imem_ready = 1'b1;
    step();
    if (InstrD !== 32'h8 || validD !== 1'b1) begin
      fails++; $display("FAIL wt_instr got=%h/%b exp=8/1", InstrD, validD);
    end
    tests++;
    if (imem_addr !== 32'hC || fetch_busy !== 1'b0) begin
      fails++; $display("FAIL wt_after got=%h/%b exp=c/0", imem_addr, fetch_busy);
    end
    tests++;
  endtask

  task automatic test_branch_wait();
    do_reset();
    for (int k = 0; k < 4; k++) step();
    if (imem_addr !== 32'h10) begin fails++; $display("FAIL bw_pre got=%h exp=10", imem_addr); end
    tests++;
    imem_ready = 1'b0;
    step();
    branch_taken = 1'b1;
    branch_target = 32'h100;
    step();
    branch_taken = 1'b0;
    if (imem_addr !== 32'h10 || fetch_busy !== 1'b1) begin
      fails++; $display("FAIL bw_hold got=%h/%b exp=10/1", imem_addr, fetch_busy);
    end
    tests++;
    imem_ready = 1'b1;
    step();
    if (imem_addr !== 32'h100) begin fails++; $display("FAIL bw_tgt got=%h exp=100", imem_addr); end
    tests++;
    if (validD !== 1'b0 || InstrD !== 32'hC) begin
      fails++; $display("FAIL bw_drop got=%h/%b exp=c/0", InstrD, validD);
    end
    tests++;
    step();
    if (InstrD !== 32'h100 || PCPlus4D !== 32'h104 || validD !== 1'b1) begin
      fails++; $display("FAIL bw_first got=%h/%h/%b exp=100/104/1", InstrD, PCPlus4D, validD);
    end
    tests++;
`ifdef FETCH_PERF_CNT_EN
    if (perf_discarded !== 32'd1) begin fails++; $display("FAIL bw_pdisc got=%0d exp=1", perf_discarded); end
    tests++;
    if (perf_fetched !== 32'd5) begin fails++; $display("FAIL bw_pfetch got=%0d exp=5", perf_fetched); end
    tests++;
`endif
  endtask

  task automatic test_stall();
    do_reset();
    for (int k = 0; k < 8; k++) step();
    if (imem_addr !== 32'h20 || InstrD !== 32'h1C) begin
      fails++; $display("FAIL st_pre got=%h/%h exp=20/1c", imem_addr, InstrD);
    end
    tests++;
    stallD = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      if (InstrD !== 32'h1C || validD !== 1'b1) begin
        fails++; $display("FAIL st_keep k=%0d got=%h/%b exp=1c/1", k, InstrD, validD);
      end
      tests++;
      if (imem_req !== 1'b0) begin fails++; $display("FAIL st_hold k=%0d got=%b exp=0", k, imem_req); end
      tests++;
    end
    stallD = 1'b0;
    step();
    if (InstrD !== 32'h20 || PCPlus4D !== 32'h24 || validD !== 1'b1) begin
      fails++; $display("FAIL st_skid got=%h/%h/%b exp=20/24/1", InstrD, PCPlus4D, validD);
    end
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h24) begin
      fails++; $display("FAIL st_resume got=%b/%h exp=1/24", imem_req, imem_addr);
    end
    tests++;
    step();
    if (InstrD !== 32'h24 || PCPlus4D !== 32'h28) begin
      fails++; $display("FAIL st_next got=%h/%h exp=24/28", InstrD, PCPlus4D);
    end
    tests++;
    step();
    if (InstrD !== 32'h28) begin fails++; $display("FAIL st_next2 got=%h exp=28", InstrD); end
    tests++;
  endtask

  task automatic test_flush_stall();
    do_reset();
    step();
    step();
    stallD = 1'b1;
    step();
    if (imem_req !== 1'b0 || InstrD !== 32'h4) begin
      fails++; $display("FAIL fs_hold got=%b/%h exp=0/4", imem_req, InstrD);
    end
    tests++;
    flushD = 1'b1;
    step();
    flushD = 1'b0;
    stallD = 1'b0;
    if (validD !== 1'b0 || InstrD !== 32'h0) begin
      fails++; $display("FAIL fs_clear got=%h/%b exp=0/0", InstrD, validD);
    end
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin
      fails++; $display("FAIL fs_pc got=%b/%h exp=1/c", imem_req, imem_addr);
    end
    tests++;
    step();
    if (InstrD !== 32'hC || validD !== 1'b1) begin
      fails++; $display("FAIL fs_skid_empty got=%h/%b exp=c/1", InstrD, validD);
    end
    tests++;
  endtask

  task automatic test_wrap();
    do_reset();
    branch_taken = 1'b1;
    branch_target = 32'hFFFF_FFFE;
    step();
    branch_taken = 1'b0;
    if (imem_addr !== 32'hFFFF_FFFC || validD !== 1'b0) begin
      fails++; $display("FAIL wr_tgt got=%h/%b exp=fffffffc/0", imem_addr, validD);
    end
    tests++;
    step();
    if (InstrD !== 32'hFFFF_FFFC || PCPlus4D !== 32'h0 || validD !== 1'b1) begin
      fails++; $display("FAIL wr_instr got=%h/%h/%b exp=fffffffc/0/1", InstrD, PCPlus4D, validD);
    end
    tests++;
    if (imem_addr !== 32'h0) begin fails++; $display("FAIL wr_addr got=%h exp=0", imem_addr); end
    tests++;
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    step();
    step();
    imem_ready = 1'b0;
    step();
    if (fetch_busy !== 1'b1) begin fails++; $display("FAIL rw_busy got=%b exp=1", fetch_busy); end
    tests++;
    #2;
    reset = 1'b0;
    #1;
    if (imem_req !== 1'b0 || fetch_busy !== 1'b0) begin
      fails++; $display("FAIL rw_async got=%b/%b exp=0/0", imem_req, fetch_busy);
    end
    tests++;
    if (InstrD !== 32'h0 || PCPlus4D !== 32'h0 || validD !== 1'b0 || imem_addr !== 32'h0) begin
      fails++; $display("FAIL rw_outs got=%h/%h/%b/%h exp=0", InstrD, PCPlus4D, validD, imem_addr);
    end
    tests++;
    imem_ready = 1'b1;
    step();
    reset = 1'b1;
    #1;
    if (imem_req !== 1'b0) begin fails++; $display("FAIL rw_idle got=%b exp=0", imem_req); end
    tests++;
    step();
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      fails++; $display("FAIL rw_first got=%b/%h exp=1/0", imem_req, imem_addr);
    end
    tests++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_wait();
    test_branch_wait();
    test_stall();
    test_flush_stall();
    test_wrap();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage feeding the decode stage of Pipeline_ARM.
- Owns the PC, issues requests to instruction memory over a req/ready handshake, and holds a 1-entry skid buffer.
- Drives the IF/ID register: InstrD, PCPlus4D and validD.
- Honours decode stall and flush, and takes branch redirects from execute, including redirects that arrive while a memory request is outstanding.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, byte increment per sequential fetch.

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address, word-aligned
- imem_ready  in  1  response valid; data on imem_rdata this cycle
- imem_rdata  in  32  fetched instruction
- stallD  in  1  hold the IF/ID register
- flushD  in  1  invalidate IF/ID and the skid buffer
- branch_taken  in  1  redirect the PC (single-cycle pulse)
- branch_target  in  32  redirect address
- InstrD  out  32  instruction to decode
- PCPlus4D  out  32  fetch PC + PC_STEP of InstrD
- validD  out  1  InstrD holds a real instruction
- fetch_busy  out  1  request outstanding

Behaviour:
- Reset (reset=0, asynchronous):
  - PC=RESET_PC, state=IDLE
  - imem_req=0, InstrD=0, PCPlus4D=0, validD=0, fetch_busy=0
  - skid buffer empty, redirect_pending=0
- FSM states:
  - IDLE: entered for exactly 1 cycle after reset deassertion, then REQ.
  - REQ: imem_req=1, imem_addr=PC.
    - imem_ready=1 at the clock edge: accept the response and stay in REQ for the next address. This gives a 1-instruction/cycle throughput with a zero-wait memory.
    - imem_ready=0: go to WAIT.
  - WAIT: imem_req=1 and imem_addr held stable until imem_ready=1, then REQ. fetch_busy=1 in WAIT.
  - HOLD: imem_req=0. Entered when the skid buffer is full and stallD=1. Return to REQ when the skid buffer drains or flushD=1.
- imem_addr must never change while imem_req=1 and imem_ready=0.
- Response routing at acceptance:
  - stallD=0 and skid empty: load the response into IF/ID (InstrD, PCPlus4D=addr+PC_STEP, validD=1).
  - stallD=0 and skid full: load IF/ID from the skid buffer; the new response goes into the skid buffer.
  - stallD=1: the response goes into the skid buffer, then HOLD.
  - Accepting while the skid buffer is full and stallD=1 is illegal; HOLD prevents it.
- stallD=1 without an acceptance: IF/ID holds all values.
- stallD=0 with no response but skid full: IF/ID loads from the skid buffer. Otherwise validD=0 for that cycle (bubble).
- PC advance: PC += PC_STEP on each accepted, non-discarded response.
- Branch redirect:
  - branch_taken=1 in REQ with imem_ready=1: PC=branch_target next cycle; the accepted response is discarded.
  - branch_taken=1 in WAIT: latch the target and set redirect_pending. The outstanding response is discarded on arrival, then fetch resumes at the target.
  - In HOLD or IDLE: PC=branch_target immediately.
- A redirect implies a flush of younger instructions only when the caller also asserts flushD; fetch_stage never self-flushes IF/ID.
- flushD=1: next cycle validD=0 and InstrD=0, and the skid buffer is emptied. flushD overrides stallD.
- Simultaneous flushD and branch_taken: both are applied. Any response accepted in that cycle is discarded.
- Arithmetic: 32-bit unsigned, wraps modulo 2^32 (0xFFFF_FFFC+4 = 0). branch_target bits[1:0] are forced to 0.
- Reset mid-WAIT: the outstanding request is abandoned and imem_req drops asynchronously.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds output ports perf_fetched[31:0] (accepted, non-discarded responses) and perf_discarded[31:0] (responses dropped by redirect or flush).
  - Both counters reset to 0, saturate at 0xFFFF_FFFF, and increment at most once per cycle.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release, zero-wait memory returning addr-as-data -> imem_addr 0,4,8,12 on consecutive cycles; InstrD 0,4,8 with validD=1 from the 3rd cycle after release; PCPlus4D=InstrD+4.
- Memory with 3 wait cycles at addr 8 -> imem_addr held at 8 for 4 cycles; fetch_busy=1; validD=0 bubbles; InstrD=8 once imem_ready asserts.
- branch_taken with target 0x100 during WAIT on addr 0x10 -> 0x10 response never reaches InstrD; next imem_addr=0x100; perf_discarded=1 with FETCH_PERF_CNT_EN.
- stallD held 3 cycles while fetching 0x20,0x24 -> InstrD stays at the pre-stall value; skid holds 0x20; imem_req=0 (HOLD); after release InstrD=0x20 then 0x24, no loss or duplicate.
- flushD together with stallD, skid full -> next cycle validD=0, InstrD=0, skid empty; fetch resumes at the current PC.
- Assert reset mid-WAIT -> imem_req=0 and all outputs 0 immediately; after release the first imem_addr=RESET_PC.
